// File: rtl/st_pkg.sv
// ============================================================================
// Module : st_pkg
// Shared op_sel encodings, special register numbers and FSM state encoding
// Rev    : 1.0
// ============================================================================
`default_nettype none

package st_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PUSH  = 8'h01;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_ADDSP = 8'h04;
    localparam logic [7:0] OP_SUBSP = 8'h08;
    localparam logic [7:0] OP_MOVSP = 8'h10;
    localparam logic [7:0] OP_ADDS  = 8'h20;
    localparam logic [7:0] OP_LDRSP = 8'h40;
    localparam logic [7:0] OP_STRSP = 8'h80;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REG  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] scale4(input logic [7:0] imm);
        return {22'd0, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/st_rlist_scan.sv
// ============================================================================
// Module : st_rlist_scan
// Lowest set index, population count and list-minus-lowest of {R,rlist}
// Rev    : 1.0
// ============================================================================
`default_nettype none

module st_rlist_scan (
    input  logic [8:0] i_list,
    output logic [3:0] o_lowest,
    output logic [3:0] o_count,
    output logic [8:0] o_rest
);

    always_comb begin
        o_lowest = 4'd0;
        o_count  = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (i_list[i]) begin
                o_lowest = 4'(i);
            end
            o_count = o_count + {3'd0, i_list[i]};
        end
    end

    assign o_rest = i_list & (i_list - 9'd1);

endmodule

`default_nettype wire

// File: rtl/st_exec_unit.sv
// ============================================================================
// Module : st_exec_unit
// Executes Thumb stack instructions: SP arithmetic and PUSH/POP/LDR/STR word transfers
// Rev    : 1.0
// ============================================================================
`default_nettype none

module st_exec_unit
    import st_pkg::*;
#(
    parameter logic [31:0] SP_RESET = 32'h0000_1000,
    parameter int          AW       = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [7:0]    i_op_sel,
    input  logic [15:0]   i_inst_in,
    output logic          o_busy,
    output logic          o_done,
    output logic [31:0]   o_sp_out,
    output logic [3:0]    o_rf_raddr,
    input  logic [31:0]   i_rf_rdata,
    output logic          o_rf_we,
    output logic [3:0]    o_rf_waddr,
    output logic [31:0]   o_rf_wdata,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,
    input  logic          i_mem_ack
);

    state_t        r_state, w_next;
    logic [7:0]    r_op;
    logic [10:0]   r_inst;
    logic [31:0]   r_sp, r_sp_new;
    logic [AW-1:0] r_addr;
    logic [8:0]    r_list;

    logic          w_onehot, w_accept, w_is_reg_op, w_is_load, w_is_store;
    logic [8:0]    w_start_list, w_scan_in, w_rest;
    logic [3:0]    w_lowest, w_count, w_reg;
    logic [31:0]   w_nbytes, w_addr_start, w_sp_final;
    logic          w_unused;

    assign w_unused    = ^i_inst_in[15:11];
    assign w_onehot    = (i_op_sel != OP_NOP) && ((i_op_sel & (i_op_sel - 8'd1)) == 8'd0);
    assign w_accept    = (r_state == S_IDLE) && i_start && w_onehot;
    assign w_is_reg_op = (i_op_sel & (OP_ADDSP | OP_SUBSP | OP_MOVSP | OP_ADDS)) != 8'd0;
    assign w_is_load   = (r_op == OP_POP) || (r_op == OP_LDRSP);
    assign w_is_store  = (r_op == OP_PUSH) || (r_op == OP_STRSP);

    // In IDLE the scanner sizes the incoming list; afterwards it walks the captured one.
    assign w_scan_in = (r_state == S_IDLE) ? w_start_list : r_list;
    assign w_nbytes  = {26'd0, w_count, 2'b00};

    st_rlist_scan u_scan (
        .i_list   (w_scan_in),
        .o_lowest (w_lowest),
        .o_count  (w_count),
        .o_rest   (w_rest)
    );

    always_comb begin
        w_start_list = 9'd0;
        w_addr_start = r_sp;
        w_sp_final   = r_sp;
        case (i_op_sel)
            OP_PUSH: begin
                w_start_list = i_inst_in[8:0];
                w_addr_start = r_sp - w_nbytes;
                w_sp_final   = r_sp - w_nbytes;
            end
            OP_POP: begin
                w_start_list = i_inst_in[8:0];
                w_sp_final   = r_sp + w_nbytes;
            end
            OP_LDRSP, OP_STRSP: begin
                w_start_list = 9'd1;
                w_addr_start = r_sp + scale4(i_inst_in[7:0]);
            end
            default: ;
        endcase
    end

    // Bit 8 of the list is LR when pushing and PC when popping.
    always_comb begin
        if ((r_op == OP_LDRSP) || (r_op == OP_STRSP)) begin
            w_reg = {1'b0, r_inst[10:8]};
        end else if (w_lowest == 4'd8) begin
            w_reg = (r_op == OP_PUSH) ? REG_LR : REG_PC;
        end else begin
            w_reg = w_lowest;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_mem_req  = 1'b0;
        o_rf_we    = 1'b0;
        o_rf_waddr = w_reg;
        o_rf_wdata = i_mem_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_reg_op)          w_next = S_REG;
                    else if (w_count == 4'd0) w_next = S_DONE;
                    else                      w_next = S_XFER;
                end
            end
            S_REG: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = S_IDLE;
                if (r_op == OP_MOVSP) begin
                    o_rf_we    = 1'b1;
                    o_rf_waddr = {1'b0, r_inst[2:0]};
                    o_rf_wdata = r_sp;
                end else if (r_op == OP_ADDS) begin
                    o_rf_we    = 1'b1;
                    o_rf_waddr = {1'b0, r_inst[10:8]};
                    o_rf_wdata = r_sp + scale4(r_inst[7:0]);
                end
            end
            S_XFER: begin
                o_busy    = 1'b1;
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    o_rf_we = w_is_load;
                    if (w_rest == 9'd0) w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op     <= OP_NOP;
            r_inst   <= 11'd0;
            r_sp     <= SP_RESET;
            r_sp_new <= SP_RESET;
            r_addr   <= '0;
            r_list   <= 9'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= i_op_sel;
                        r_inst   <= i_inst_in[10:0];
                        r_list   <= w_start_list;
                        r_addr   <= w_addr_start[AW-1:0];
                        r_sp_new <= w_sp_final;
                    end
                end
                S_REG: begin
                    if (r_op == OP_ADDSP) begin
                        r_sp <= r_sp + scale4({1'b0, r_inst[6:0]});
                    end else if (r_op == OP_SUBSP) begin
                        r_sp <= r_sp - scale4({1'b0, r_inst[6:0]});
                    end
                end
                S_XFER: begin
                    if (i_mem_ack) begin
                        r_list <= w_rest;
                        r_addr <= r_addr + AW'(4);
                        if (w_rest == 9'd0) r_sp <= r_sp_new;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sp_out    = r_sp;
    assign o_rf_raddr  = w_reg;
    assign o_mem_we    = (r_state == S_XFER) && w_is_store;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = i_rf_rdata;

endmodule

`default_nettype wire

// File: tb/tb_st_exec_unit.sv
// ============================================================================
// Module : tb_st_exec_unit
// Directed bench for st_exec_unit with register file and memory models
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_st_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  op_sel = 8'h00;
    logic [15:0] inst = 16'h0000;
    logic        busy, dut_done, rf_we, mem_req, mem_we;
    logic [31:0] sp, rf_wdata, mem_addr, mem_wdata, rf_rdata, mem_rdata;
    logic [3:0]  rf_raddr, rf_waddr;
    logic        mem_ack = 1'b0;

    int n_err = 0;
    int n_chk = 0;
    int done_cnt = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    bit rf_init = 1'b1;
    bit mon_en = 1'b0;
    logic [31:0] mon_addr = 32'd0;

    logic [31:0] rf [16];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } mlog_t;
    mlog_t mlog[$];

    typedef struct {
        logic [7:0]  op;
        logic [15:0] inst;
        logic [31:0] sp;
        bit          chk_rf;
        logic [3:0]  ra;
        logic [31:0] rv;
    } vec_t;
    vec_t tbl[17];

    always #5 clk = ~clk;

    st_exec_unit dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_op_sel    (op_sel),
        .i_inst_in   (inst),
        .o_busy      (busy),
        .o_done      (dut_done),
        .o_sp_out    (sp),
        .o_rf_raddr  (rf_raddr),
        .i_rf_rdata  (rf_rdata),
        .o_rf_we     (rf_we),
        .o_rf_waddr  (rf_waddr),
        .o_rf_wdata  (rf_wdata),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack)
    );

    assign rf_rdata  = rf[rf_raddr];
    assign mem_rdata = {16'hD00D, mem_addr[15:0]};

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'hA000_0000 + i;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
        if (mem_req && mem_ack) mlog.push_back('{mem_we, mem_addr, mem_wdata});
        if (dut_done) done_cnt++;
    end

    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && mem_req) begin
            chk("ldr_addr_stable", mem_addr, mon_addr);
            chk("ldr_we_low", {31'd0, mem_we}, 32'd0);
        end
    end

    // Issue one command; lat is the number of cycles between busy rising and done.
    task automatic run_cmd(input logic [7:0] op, input logic [15:0] ins, output bit got, output int lat);
        @(negedge clk);
        start = 1'b1; op_sel = op; inst = ins;
        @(negedge clk);
        start = 1'b0; op_sel = 8'h00;
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (dut_done) got = 1'b1;
            else begin
                lat++;
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit got;
        int lat;
        int mb;
        int dc;

        for (int k = 0; k < 8; k++)
            tbl[k] = '{8'h08, 16'hB0FF, 32'h1000 - (k + 1) * 32'h1FC, 1'b0, 4'd0, 32'd0};
        tbl[8]  = '{8'h08, 16'hB087, 32'h0000_0004, 1'b0, 4'd0, 32'd0};
        tbl[9]  = '{8'h08, 16'hB082, 32'hFFFF_FFFC, 1'b0, 4'd0, 32'd0};
        tbl[10] = '{8'h10, 16'h466A, 32'hFFFF_FFFC, 1'b1, 4'd2, 32'hFFFF_FFFC};
        tbl[11] = '{8'h20, 16'hA9FF, 32'hFFFF_FFFC, 1'b1, 4'd1, 32'h0000_03F8};
        tbl[12] = '{8'h04, 16'hB002, 32'h0000_0004, 1'b0, 4'd0, 32'd0};
        tbl[13] = '{8'h10, 16'h466A, 32'h0000_0004, 1'b1, 4'd2, 32'h0000_0004};
        tbl[14] = '{8'h20, 16'hA902, 32'h0000_0004, 1'b1, 4'd1, 32'h0000_000C};
        tbl[15] = '{8'h04, 16'hB07F, 32'h0000_0200, 1'b0, 4'd0, 32'd0};
        tbl[16] = '{8'h08, 16'hB0FF, 32'h0000_0004, 1'b0, 4'd0, 32'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rf_init = 1'b0;
        rst = 1'b0;

        // Reset state and ignored commands
        chk("rst_sp", sp, 32'h1000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, dut_done}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        start = 1'b1; op_sel = 8'h00; inst = 16'hB505;
        @(negedge clk);
        chk("nop_busy", {31'd0, busy}, 32'd0);
        op_sel = 8'h03;
        @(negedge clk);
        chk("multihot_busy", {31'd0, busy}, 32'd0);
        start = 1'b0; op_sel = 8'h00;
        @(negedge clk);
        chk("ignored_no_done", done_cnt, 0);

        // PUSH {r0,r2,lr}
        mb = mlog.size();
        run_cmd(8'h01, 16'hB505, got, lat);
        chk("push_done", {31'd0, got}, 32'd1);
        chk("push_cnt", mlog.size(), mb + 3);
        if (mlog.size() == mb + 3) begin
            chk("push0_we", {31'd0, mlog[mb].we}, 32'd1);
            chk("push0_addr", mlog[mb].addr, 32'hFF4);
            chk("push0_data", mlog[mb].data, 32'hA000_0000);
            chk("push1_addr", mlog[mb+1].addr, 32'hFF8);
            chk("push1_data", mlog[mb+1].data, 32'hA000_0002);
            chk("push2_addr", mlog[mb+2].addr, 32'hFFC);
            chk("push2_data", mlog[mb+2].data, 32'hA000_000E);
        end
        chk("push_sp", sp, 32'hFF4);

        // POP {r1,pc}
        mb = mlog.size();
        run_cmd(8'h02, 16'hBD02, got, lat);
        chk("pop_done", {31'd0, got}, 32'd1);
        chk("pop_cnt", mlog.size(), mb + 2);
        if (mlog.size() == mb + 2) begin
            chk("pop0_we", {31'd0, mlog[mb].we}, 32'd0);
            chk("pop0_addr", mlog[mb].addr, 32'hFF4);
            chk("pop1_addr", mlog[mb+1].addr, 32'hFF8);
        end
        chk("pop_r1", rf[1], 32'hD00D_0FF4);
        chk("pop_r15", rf[15], 32'hD00D_0FF8);
        chk("pop_sp", sp, 32'hFFC);

        // SP arithmetic vectors, including wrap through zero
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            run_cmd(tbl[i].op, tbl[i].inst, got, lat);
            chk($sformatf("reg%0d_done", i), {31'd0, got}, 32'd1);
            chk($sformatf("reg%0d_lat", i), lat, 0);
            chk($sformatf("reg%0d_sp", i), sp, tbl[i].sp);
            if (tbl[i].chk_rf) chk($sformatf("reg%0d_rf", i), rf[tbl[i].ra], tbl[i].rv);
        end

        // LDR r3,[sp,#12] with slow ack, then STR r3,[sp,#12]
        ack_delay = 3;
        mon_addr = 32'h10;
        mon_en = 1'b1;
        mb = mlog.size();
        run_cmd(8'h40, 16'h9B03, got, lat);
        mon_en = 1'b0;
        chk("ldr_done", {31'd0, got}, 32'd1);
        chk("ldr_cnt", mlog.size(), mb + 1);
        chk("ldr_r3", rf[3], 32'hD00D_0010);
        chk("ldr_sp", sp, 32'h4);
        mb = mlog.size();
        run_cmd(8'h80, 16'h9303, got, lat);
        chk("str_done", {31'd0, got}, 32'd1);
        chk("str_cnt", mlog.size(), mb + 1);
        if (mlog.size() == mb + 1) begin
            chk("str_we", {31'd0, mlog[mb].we}, 32'd1);
            chk("str_addr", mlog[mb].addr, 32'h10);
            chk("str_data", mlog[mb].data, 32'hD00D_0010);
        end
        chk("str_sp", sp, 32'h4);

        // Empty PUSH list
        ack_delay = 0;
        mb = mlog.size();
        run_cmd(8'h01, 16'hB400, got, lat);
        chk("empty_done", {31'd0, got}, 32'd1);
        chk("empty_lat", lat, 0);
        chk("empty_cnt", mlog.size(), mb);
        chk("empty_sp", sp, 32'h4);

        // Reset in the middle of a PUSH, with a start issued while busy
        pulse_reset();
        ack_delay = 1;
        mb = mlog.size();
        @(negedge clk);
        start = 1'b1; op_sel = 8'h01; inst = 16'hB505;
        @(negedge clk);
        op_sel = 8'h02; inst = 16'hBD02;
        @(negedge clk);
        start = 1'b0; op_sel = 8'h00;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (mlog.size() > mb) got = 1'b1;
            else @(negedge clk);
        end
        chk("mid_first_ack", {31'd0, got}, 32'd1);
        if (mlog.size() > mb) begin
            chk("mid_first_we", {31'd0, mlog[mb].we}, 32'd1);
            chk("mid_first_addr", mlog[mb].addr, 32'hFF4);
        end
        dc = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_req_drop", {31'd0, mem_req}, 32'd0);
        chk("mid_rfwe_drop", {31'd0, rf_we}, 32'd0);
        chk("mid_sp", sp, 32'h1000);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_done", done_cnt, dc);
        chk("mid_one_xfer", mlog.size(), mb + 1);
        ack_delay = 0;
        run_cmd(8'h04, 16'hB002, got, lat);
        chk("after_done", {31'd0, got}, 32'd1);
        chk("after_sp", sp, 32'h1008);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
